// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix pins plus the decoded-key outputs of keypad_scanner.
// The scanner side uses master; the keypad/consumer side uses slave.
interface keypad_scanner_if;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] value;
   logic        multi;

   modport master (
      input  rows,
      output cols,
      output key_valid,
      output key_code,
      output value,
      output multi
   );

   modport slave (
      output rows,
      input  cols,
      input  key_valid,
      input  key_code,
      input  value,
      input  multi
   );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad one column at a time, debounces whole frames and keeps
// the last four accepted keys. Define KEYPAD_AUTOREPEAT_EN to re-emit a key that stays held.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV        = 10000,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter int unsigned REPEAT_FRAMES   = 50
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master kp
);

   localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW  = $clog2(DEBOUNCE_FRAMES + 1);

   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0]  DebLast  = CntW'(DEBOUNCE_FRAMES);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);

   typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} state_e;

   logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;
   logic [1:0]       col_idx_q, col_idx_d;
   // Keys seen so far in this frame, saturating at 2: only 0, 1 and "many" matter.
   logic [1:0]       acc_cnt_q, acc_cnt_d;
   logic [3:0]       acc_code_q, acc_code_d;
   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [3:0]       cand_q, cand_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic [15:0]      value_q, value_d;
   logic             multi_q, multi_d;

   logic             tc;
   logic             frame_end;
   logic [3:0]       pressed;
   logic [2:0]       slot_hits;
   logic [1:0]       slot_row;
   logic [3:0]       slot_code;
   logic [2:0]       acc_sum;
   logic [1:0]       frame_cnt;
   logic [3:0]       frame_code;
   logic             key_ok;
   logic             accept;
   logic             rep_fire;
   logic [CntW-1:0]  cnt_inc;

   function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
      logic [3:0] code;
      unique case ({col, row})
         4'h0: code = 4'h1;
         4'h1: code = 4'h4;
         4'h2: code = 4'h7;
         4'h3: code = 4'h0;
         4'h4: code = 4'h2;
         4'h5: code = 4'h5;
         4'h6: code = 4'h8;
         4'h7: code = 4'hF;
         4'h8: code = 4'h3;
         4'h9: code = 4'h6;
         4'hA: code = 4'h9;
         4'hB: code = 4'hE;
         4'hC: code = 4'hA;
         4'hD: code = 4'hB;
         4'hE: code = 4'hC;
         4'hF: code = 4'hD;
      endcase
      return code;
   endfunction

   // Slot timing, row sampling and per-frame accumulation.
   always_comb begin
      tc         = (slot_cnt_q == SlotLast);
      frame_end  = tc && (col_idx_q == 2'd3);
      slot_cnt_d = tc ? '0 : slot_cnt_q + 1'b1;
      col_idx_d  = tc ? col_idx_q + 2'd1 : col_idx_q;

      pressed   = ~kp.rows;
      slot_hits = {2'b00, pressed[0]} + {2'b00, pressed[1]} +
                  {2'b00, pressed[2]} + {2'b00, pressed[3]};

      if (pressed[0]) begin
         slot_row = 2'd0;
      end else if (pressed[1]) begin
         slot_row = 2'd1;
      end else if (pressed[2]) begin
         slot_row = 2'd2;
      end else begin
         slot_row = 2'd3;
      end
      slot_code = key_map(col_idx_q, slot_row);

      acc_sum    = {1'b0, acc_cnt_q} + ((slot_hits > 3'd1) ? 3'd2 : slot_hits);
      frame_cnt  = (acc_sum > 3'd1) ? 2'd2 : acc_sum[1:0];
      frame_code = (acc_cnt_q != 2'd0) ? acc_code_q : slot_code;
      key_ok     = (frame_cnt == 2'd1);

      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      if (frame_end) begin
         acc_cnt_d  = 2'd0;
         acc_code_d = 4'h0;
      end else if (tc) begin
         acc_cnt_d  = frame_cnt;
         acc_code_d = frame_code;
      end
   end

   // Debounce FSM, advanced once per frame.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      cnt_inc = cnt_q + 1'b1;

      if (frame_end) begin
         unique case (state_q)
            StIdle: begin
               if (key_ok) begin
                  cand_d = frame_code;
                  cnt_d  = CntOne;
                  if (CntOne == DebLast) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                  end else begin
                     state_d = StPress;
                  end
               end
            end
            StPress: begin
               if (!key_ok) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (frame_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DebLast) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                  end
               end else begin
                  cand_d = frame_code;
                  cnt_d  = CntOne;
               end
            end
            StHeld: begin
               if (!key_ok) begin
                  // A single-frame release window needs no RELEASE visit.
                  if (CntOne == DebLast) begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     state_d = StRelease;
                     cnt_d   = CntOne;
                  end
               end
            end
            StRelease: begin
               if (key_ok) begin
                  state_d = StHeld;
               end else if (cnt_inc == DebLast) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RepW = $clog2(2 * REPEAT_FRAMES + 1);

   localparam logic [RepW-1:0] RepFirst  = RepW'(2 * REPEAT_FRAMES);
   localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_FRAMES);

   logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
   logic [RepW-1:0] rep_inc;

   // Reloading with one period after a re-emit spaces later re-emits REPEAT_FRAMES apart.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_fire  = 1'b0;
      rep_inc   = rep_cnt_q + 1'b1;
      if (frame_end) begin
         if ((state_q == StHeld) && key_ok) begin
            if (rep_inc == RepFirst) begin
               rep_fire  = 1'b1;
               rep_cnt_d = RepPeriod;
            end else begin
               rep_cnt_d = rep_inc;
            end
         end else begin
            rep_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      key_valid_d = accept | rep_fire;
      key_code_d  = accept ? cand_d : key_code_q;
      value_d     = value_q;
      if (accept) begin
         value_d = {value_q[11:0], cand_d};
      end else if (rep_fire) begin
         value_d = {value_q[11:0], cand_q};
      end
      multi_d = frame_end ? (frame_cnt == 2'd2) : multi_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q  <= '0;
         col_idx_q   <= 2'd0;
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'h0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         cand_q      <= 4'h0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         value_q     <= 16'h0000;
         multi_q     <= 1'b0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         col_idx_q   <= col_idx_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         value_q     <= value_d;
         multi_q     <= multi_d;
      end
   end

   assign kp.cols      = ~(4'b0001 << col_idx_q);
   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;
   assign kp.value     = value_q;
   assign kp.multi     = multi_q;

endmodule
